// File: rtl/lsu_bus_port.sv
// Load/store bus port: legality check, byte-lane alignment, req/ack bus handshake, load extension.
// Latency: bus_req one cycle after start, done one cycle after ack (faults: done one cycle after start).
// Backpressure: bus_req holds until bus_ack or timeout; start is ignored while busy.
module lsu_bus_port #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
        logic [1:0] off;
    } req_t;

    state_t        state;
    req_t          cur;
    logic [CW-1:0] tmo_cnt;

    logic [1:0]    off;
    logic          legal;
    logic          misal;
    logic [3:0]    be_nxt;
    logic [31:0]   ld_shift;
    logic [31:0]   ld_dat;
    logic          tmo_hit;

    assign off = addr[1:0];
    assign tmo_hit = (TIMEOUT_CYCLES > 0) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        legal = is_store ? (funct3 inside {3'b000, 3'b001, 3'b010})
                         : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        // funct3[1:0] encodes size for both signed and unsigned loads
        misal = ((funct3[1:0] == 2'b01) && off[0]) ||
                ((funct3[1:0] == 2'b10) && (off != 2'b00));
        case (funct3[1:0])
            2'b00:   be_nxt = 4'b0001 << off;
            2'b01:   be_nxt = 4'b0011 << off;
            default: be_nxt = 4'b1111;
        endcase
    end

    always_comb begin
        ld_shift = bus_rdata >> {cur.off, 3'b000};
        case (cur.funct3)
            3'b000:  ld_dat = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_dat = {24'h0, ld_shift[7:0]};
            3'b001:  ld_dat = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_dat = {16'h0, ld_shift[15:0]};
            default: ld_dat = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            tmo_cnt   <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            rdata     <= '0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur     <= '{is_store, funct3, off};
                        tmo_cnt <= '0;
                        busy    <= 1'b1;
                        if (!legal || misal) begin
                            state <= ERR;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else begin
                            state     <= REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= is_store;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= be_nxt;
                            bus_wdata <= is_store ? (wdata << {off, 3'b000}) : 32'h0;
                        end
                    end
                end
                REQ: begin
                    // an ack arriving on the timeout cycle still completes normally
                    if (bus_ack) begin
                        if (!cur.is_store) rdata <= ld_dat;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        state   <= RESP;
                        done    <= 1'b1;
                    end else if (tmo_hit) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        state   <= ERR;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_bus_port.sv
// Scoreboard bench for lsu_bus_port: stimulus queues expected bus beats and completions,
// a negedge monitor pops and compares them whenever bus_req rises or done pulses.
module tb_lsu_bus_port;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct packed {
        logic        fault;
        logic [31:0] rdata;
    } done_exp_t;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];
    int n_cmp = 0;
    int n_err = 0;

    lsu_bus_port #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .busy(busy), .done(done), .fault(fault), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got unexpected event expected none at %0t", nm, $time);
    endtask

    // Monitor: compare bus beats against the queued expectation every REQ cycle, completions on done.
    initial begin : monitor
        bus_exp_t  cb;
        done_exp_t cd;
        logic      prev_req;
        prev_req = 1'b0;
        cb = '0;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                if (!prev_req) begin
                    if (bus_q.size() == 0) flag("bus_req_unexpected");
                    else cb = bus_q.pop_front();
                end
                chk("bus_we", bus_we, cb.we);
                chk("bus_addr", bus_addr, cb.addr);
                chk("bus_be", bus_be, cb.be);
                chk("bus_wdata", bus_wdata, cb.wdata);
            end
            prev_req = bus_req;
            if (done) begin
                if (done_q.size() == 0) flag("done_unexpected");
                else begin
                    cd = done_q.pop_front();
                    chk("fault", fault, cd.fault);
                    chk("rdata", rdata, cd.rdata);
                end
            end
        end
    end

    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int dly, input logic [31:0] brd,
                          input logic ef, input logic [31:0] eaddr, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd, input bit pulse);
        if (!ef) bus_q.push_back('{st, eaddr, ebe, ewd});
        done_q.push_back('{ef, erd});
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0;
        if (ef) begin
            chk("fault_done_latency", done, 1);
            chk("fault_no_req", bus_req, 0);
        end else begin
            chk("req_latency", bus_req, 1);
            chk("busy_in_req", busy, 1);
            for (int i = 0; i < dly; i++) begin
                if (pulse && i == 0) begin
                    start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h7000; wdata = 32'hFF;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
            bus_ack = 1'b1; bus_rdata = brd;
            @(posedge clk); #1;
            bus_ack = 1'b0; bus_rdata = 32'h0;
            chk("ack_done_latency", done, 1);
            chk("req_dropped", bus_req, 0);
        end
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_not_busy", busy, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //     st  f3      addr          wdata         dly brd            ef  eaddr         be       ewdata        erd           pulse
        access(1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0,         0, 32'h0000_1000, 4'b1000, 32'hA500_0000, 32'h0000_0000, 0);
        access(0, 3'b000, 32'h0000_2002, 32'h0,         0, 32'h12F3_4567, 0, 32'h0000_2000, 4'b0100, 32'h0,         32'hFFFF_FFF3, 0);
        access(0, 3'b100, 32'h0000_2002, 32'h0,         1, 32'h12F3_4567, 0, 32'h0000_2000, 4'b0100, 32'h0,         32'h0000_00F3, 0);
        access(0, 3'b001, 32'h0000_2002, 32'h0,         0, 32'h8001_7FFF, 0, 32'h0000_2000, 4'b1100, 32'h0,         32'hFFFF_8001, 0);
        access(0, 3'b101, 32'h0000_2002, 32'h0,         2, 32'h8001_7FFF, 0, 32'h0000_2000, 4'b1100, 32'h0,         32'h0000_8001, 0);
        access(0, 3'b010, 32'h0000_3001, 32'h0,         0, 32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0000_8001, 0);
        access(1, 3'b001, 32'h0000_3003, 32'h0000_1234, 0, 32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0000_8001, 0);
        access(0, 3'b011, 32'h0000_3000, 32'h0,         0, 32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0000_8001, 0);
        access(1, 3'b100, 32'h0000_3000, 32'h0,         0, 32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0000_8001, 0);
        access(1, 3'b001, 32'h0000_6002, 32'h0000_1234, 0, 32'h0,         0, 32'h0000_6000, 4'b1100, 32'h1234_0000, 32'h0000_8001, 0);
        access(1, 3'b010, 32'h0000_4008, 32'h1122_3344, 3, 32'h0,         0, 32'h0000_4008, 4'b1111, 32'h1122_3344, 32'h0000_8001, 0);
        access(0, 3'b010, 32'h0000_5004, 32'h0,         3, 32'hCAFE_BABE, 0, 32'h0000_5004, 4'b1111, 32'h0,         32'hCAFE_BABE, 1);

        // Store that never sees an ack: bus_req must stay up for exactly four cycles.
        bus_q.push_back('{1'b1, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF});
        done_q.push_back('{1'b1, 32'hCAFE_BABE});
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h0000_4000; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (bus_req && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("timeout_req_cycles", n, 4);
        chk("timeout_done", done, 1);
        @(posedge clk); #1;
        chk("timeout_idle", busy, 0);

        // Reset in the middle of a load: access is abandoned and a late ack is ignored.
        bus_q.push_back('{1'b0, 32'h0000_8000, 4'b1111, 32'h0});
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_8000; wdata = 32'h0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst_mid_req_up", bus_req, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_bus_req", bus_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rdata", rdata, 0);
        chk("rst_mid_done", done, 0);
        rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        chk("late_ack_no_done", done, 0);
        @(posedge clk); #1;
        chk("late_ack_no_done2", done, 0);
        chk("late_ack_rdata", rdata, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("bus_q_drained", bus_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
